// File: rtl/pe_mac_unit_pkg.sv
// Shared definitions for the PE MAC stage: FSM encoding and default datapath widths.
package pe_mac_unit_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_K      = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int KSIZE_WIDTH    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    OUT    = 3'd4
  } pe_state_t;

endpackage

// File: rtl/pe_mac_unit_act_line_buf.sv
// Activation line buffer: one kernel window of activations, written in order and read by tap index.
module pe_act_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 16,
  localparam int IDX_W     = $clog2(MAX_K),
  localparam int CNT_W     = $clog2(MAX_K + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [MAX_K];
  logic [CNT_W-1:0]      wr_ptr;

  // Writes beyond the array depth are dropped so the pointer can never alias a slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      for (int i = 0; i < MAX_K; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < MAX_K; i++) mem[i] <= '0;
    end else if (wr_en && (wr_ptr < CNT_W'(MAX_K))) begin
      mem[wr_ptr[IDX_W-1:0]] <= wr_data;
      wr_ptr                 <= wr_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = wr_ptr;

endmodule

// File: rtl/pe_mac_unit.sv
// PE MAC stage: buffers one activation window, streams K weights, accumulates the signed
// products and hands a saturated partial sum to the output collector.
module pe_mac_unit
  import pe_mac_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_K      = DEF_MAX_K,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [KSIZE_WIDTH-1:0] kernel_size,
  input  logic                   kernel_busy,
  input  logic                   un_configed,
  output logic                   weight_rd_en,
  input  logic [DATA_WIDTH-1:0]  weight_in,
  input  logic [DATA_WIDTH-1:0]  act_in,
  input  logic                   act_valid,
  output logic                   act_ready,
  output logic [OUT_WIDTH-1:0]   psum_out,
  output logic                   psum_valid,
  input  logic                   psum_ready,
  output logic                   busy,
  output logic                   start_err
);

  localparam int IDX_W  = $clog2(MAX_K);
  localparam int CNT_W  = $clog2(MAX_K + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  pe_state_t state, next_state;

  logic [CNT_W-1:0]            k_reg;
  logic [IDX_W-1:0]            tap;
  logic signed [PROD_W-1:0]    prod;
  logic                        prod_vld;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0]        sat_val;

  logic [DATA_WIDTH-1:0]       lb_rd_data;
  logic [CNT_W-1:0]            lb_count;

  logic start_ok;
  logic act_fire;
  logic load_done;
  logic stream_last;

  assign start_ok = start && !kernel_busy && !un_configed &&
                    (kernel_size != '0) &&
                    (kernel_size <= KSIZE_WIDTH'(MAX_K));

  assign act_fire    = act_valid && act_ready;
  assign load_done   = act_fire && (lb_count == (k_reg - 1'b1));
  assign stream_last = (CNT_W'(tap) == (k_reg - 1'b1));

  pe_act_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_K      (MAX_K)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .clear   ((state == IDLE) && start_ok),
    .wr_en   (act_fire),
    .wr_data (act_in),
    .rd_idx  (tap),
    .rd_data (lb_rd_data),
    .count   (lb_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_ok)    next_state = LOAD;
      LOAD:    if (load_done)   next_state = STREAM;
      STREAM:  if (stream_last) next_state = DRAIN;
      DRAIN:                    next_state = OUT;
      OUT:     if (psum_ready)  next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  always_comb begin
    act_ready    = 1'b0;
    weight_rd_en = 1'b0;
    psum_valid   = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE:    busy         = 1'b0;
      LOAD:    act_ready    = (lb_count < k_reg);
      STREAM:  weight_rd_en = 1'b1;
      DRAIN:   ;
      OUT:     psum_valid   = 1'b1;
      default: busy         = 1'b0;
    endcase
  end

  // The product register delays each tap by one cycle, so the last product lands during DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_reg     <= '0;
      tap       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= (state == IDLE) && start && !start_ok;
      prod_vld  <= (state == STREAM);
      if (state == STREAM) begin
        prod <= $signed(weight_in) * $signed(lb_rd_data);
        tap  <= tap + 1'b1;
      end
      if ((state == IDLE) && start_ok) begin
        k_reg <= kernel_size[CNT_W-1:0];
        tap   <= '0;
        acc   <= '0;
      end else if (prod_vld) begin
        acc <= acc + {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
  end

  always_comb begin
    if (acc > SAT_HI)      sat_val = SAT_HI[OUT_WIDTH-1:0];
    else if (acc < SAT_LO) sat_val = SAT_LO[OUT_WIDTH-1:0];
    else                   sat_val = acc[OUT_WIDTH-1:0];
  end

  assign psum_out = psum_valid ? sat_val : '0;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed self-checking bench for pe_mac_unit with a behavioural dot-product model.
module tb_pe_mac_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  kernel_size;
  logic        kernel_busy;
  logic        un_configed;
  logic        weight_rd_en;
  logic [15:0] weight_in;
  logic [15:0] act_in;
  logic        act_valid;
  logic        act_ready;
  logic [31:0] psum_out;
  logic        psum_valid;
  logic        psum_ready;
  logic        busy;
  logic        start_err;

  logic signed [15:0] wmem    [16];
  logic signed [15:0] act_vec [16];
  logic [4:0]         wptr;

  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  int          exp_k;
  logic [31:0] exp_psum;
  int          cyc = 0;
  int          s0_cyc;
  int          rd_run;
  int          runs_done;
  bit          valid_seen;
  logic [31:0] got;

  pe_mac_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .kernel_size  (kernel_size),
    .kernel_busy  (kernel_busy),
    .un_configed  (un_configed),
    .weight_rd_en (weight_rd_en),
    .weight_in    (weight_in),
    .act_in       (act_in),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .psum_out     (psum_out),
    .psum_valid   (psum_valid),
    .psum_ready   (psum_ready),
    .busy         (busy),
    .start_err    (start_err)
  );

  always #5 clk = ~clk;

  // Weight buffer read side: restarts on an accepted start, auto-advances on each read.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)                  wptr <= '0;
    else if (start && !busy)    wptr <= '0;
    else if (weight_rd_en)      wptr <= wptr + 5'd1;
  end
  assign weight_in = weight_rd_en ? wmem[wptr[3:0]] : 16'h0000;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelPsum(input int k);
    longint s = 0;
    for (int i = 0; i < k; i++) s += longint'(wmem[i]) * longint'(act_vec[i]);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (weight_rd_en) begin
          if (rd_run == 0) s0_cyc = cyc;
          rd_run++;
        end else if (rd_run != 0) begin
          checkOutput("rd_en_run_length", 64'(rd_run), 64'(exp_k));
          runs_done++;
          rd_run = 0;
        end
        if (psum_valid) begin
          if (!valid_seen) begin
            checkOutput("psum_latency", 64'(cyc - s0_cyc), 64'(exp_k + 1));
            valid_seen = 1'b1;
          end
          checkOutput("psum_model", 64'(psum_out), 64'(exp_psum));
        end
      end
    end
  endtask

  task automatic applyStimulus(input int k, input bit toggle, input int hold,
                               input bit poke_start, output logic [31:0] result);
    int ready_miss = 0;
    int n = 0;
    exp_k      = k;
    exp_psum   = modelPsum(k);
    rd_run     = 0;
    runs_done  = 0;
    valid_seen = 1'b0;
    mon_en     = 1'b1;
    start       = 1'b1;
    kernel_size = 8'(k);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("accept_busy", 64'(busy), 64'd1);
    for (int i = 0; i < k; i++) begin
      if (toggle) begin
        act_valid = 1'b0;
        @(posedge clk); #1;
      end
      act_in    = act_vec[i];
      act_valid = 1'b1;
      if (!act_ready) ready_miss++;
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
    checkOutput("act_ready_during_load", 64'(ready_miss), 64'd0);
    checkOutput("act_ready_after_load", 64'(act_ready), 64'd0);
    while (!psum_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!psum_valid) checkOutput("psum_valid_timeout", 64'(psum_valid), 64'd1);
    psum_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (poke_start && i == 1) begin
        start       = 1'b1;
        kernel_size = 8'(k);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("start_err_while_busy", 64'(start_err), 64'd0);
      checkOutput("psum_valid_hold", 64'(psum_valid), 64'd1);
    end
    psum_ready = 1'b1;
    result     = psum_out;
    @(posedge clk); #1;
    psum_ready = 1'b0;
    checkOutput("idle_after_handshake", 64'(busy), 64'd0);
    checkOutput("valid_after_handshake", 64'(psum_valid), 64'd0);
    mon_en = 1'b0;
    checkOutput("psum_valid_seen", 64'(valid_seen), 64'd1);
    checkOutput("rd_en_single_run", 64'(runs_done), 64'd1);
  endtask

  task automatic rejectCase(input string name, input bit ub, input bit kb, input logic [7:0] ks);
    int pulses = 0;
    int busy_hi = 0;
    un_configed = ub;
    kernel_busy = kb;
    kernel_size = ks;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (start_err) pulses++;
      if (busy) busy_hi++;
      @(posedge clk); #1;
    end
    checkOutput({name, "_err_pulses"}, 64'(pulses), 64'd1);
    checkOutput({name, "_busy"}, 64'(busy_hi), 64'd0);
    un_configed = 1'b0;
    kernel_busy = 1'b0;
  endtask

  initial begin
    int n;
    rstn        = 1'b0;
    start       = 1'b0;
    kernel_size = 8'd0;
    kernel_busy = 1'b0;
    un_configed = 1'b0;
    act_in      = 16'h0;
    act_valid   = 1'b0;
    psum_ready  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wmem[i]    = 16'sd0;
      act_vec[i] = 16'sd0;
    end
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_psum_out", 64'(psum_out), 64'd0);
    checkOutput("reset_psum_valid", 64'(psum_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_weight_rd_en", 64'(weight_rd_en), 64'd0);
    checkOutput("reset_act_ready", 64'(act_ready), 64'd0);
    checkOutput("reset_start_err", 64'(start_err), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      wmem[i]    = 16'(i + 1);
      act_vec[i] = 16'sd2;
    end
    applyStimulus(9, 1'b0, 0, 1'b0, got);
    checkOutput("k9_psum_literal", 64'(got), 64'd90);
    applyStimulus(9, 1'b1, 0, 1'b0, got);
    checkOutput("k9_gapped_psum_literal", 64'(got), 64'd90);

    for (int i = 0; i < 3; i++) begin
      wmem[i]    = 16'sh7FFF;
      act_vec[i] = 16'sh7FFF;
    end
    applyStimulus(3, 1'b0, 5, 1'b1, got);
    checkOutput("sat_pos_literal", 64'(got), 64'h7FFF_FFFF);
    for (int i = 0; i < 3; i++) wmem[i] = 16'sh8000;
    applyStimulus(3, 1'b0, 0, 1'b0, got);
    checkOutput("sat_neg_literal", 64'(got), 64'h8000_0000);

    rejectCase("rej_unconfiged", 1'b1, 1'b0, 8'd4);
    rejectCase("rej_kernel_busy", 1'b0, 1'b1, 8'd4);
    rejectCase("rej_k0", 1'b0, 1'b0, 8'd0);
    rejectCase("rej_k17", 1'b0, 1'b0, 8'd17);

    for (int i = 0; i < 9; i++) begin
      wmem[i]    = 16'(i + 1);
      act_vec[i] = 16'sd2;
    end
    start       = 1'b1;
    kernel_size = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      act_in    = act_vec[i];
      act_valid = 1'b1;
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
    n = 0;
    while (!weight_rd_en && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stream_reached", 64'(weight_rd_en), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_weight_rd_en", 64'(weight_rd_en), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_psum_valid", 64'(psum_valid), 64'd0);
    checkOutput("midrst_psum_out", 64'(psum_out), 64'd0);
    checkOutput("midrst_act_ready", 64'(act_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      wmem[i]    = 16'sd1;
      act_vec[i] = 16'sd1;
    end
    applyStimulus(4, 1'b0, 0, 1'b0, got);
    checkOutput("post_reset_k4_literal", 64'(got), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
